mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO; sequences MULT/MULTU/DIV/DIVU over a fixed busy window.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles, result visible the cycle after; MTHI/MTLO visible next cycle.
// Backpressure: stall = md_use_d & (start | busy); start while busy is dropped. Optional cancel under `MDU_CANCEL_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_use_d,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [4:0] MUL_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count, count_nxt;
  logic [2:0]  op_q, op_nxt;
  logic [31:0] a_q, a_nxt;
  logic [31:0] b_q, b_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [31:0] res_hi, res_lo;
  logic        kill;

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic signed [31:0] sdivisor, sq, sr;
  logic        [31:0] udivisor, uq, ur;

`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  // Result datapath from the latched operands; divisors are forced to 1 for the
  // divide-by-zero and most-negative/-1 cases so the operators never see them.
  always_comb begin
    sprod    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    uprod    = {32'd0, a_q} * {32'd0, b_q};
    sdivisor = ((b_q == 32'd0) || (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF))
               ? 32'sd1 : $signed(b_q);
    sq       = $signed(a_q) / sdivisor;
    sr       = $signed(a_q) % sdivisor;
    udivisor = (b_q == 32'd0) ? 32'd1 : b_q;
    uq       = a_q / udivisor;
    ur       = a_q % udivisor;
    res_hi   = hi;
    res_lo   = lo;
    case (op_q)
      OP_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      OP_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      OP_DIV: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
  end

  // Next-state: accept ops in IDLE, count down in RUN, write HI/LO on the last cycle.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    op_nxt    = op_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_nxt    = op;
              a_nxt     = a;
              b_nxt     = b;
              count_nxt = MUL_LOAD;
              state_nxt = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_nxt    = op;
              a_nxt     = a;
              b_nxt     = b;
              count_nxt = DIV_LOAD;
              state_nxt = RUN;
            end
            OP_MTHI: hi_nxt = a;
            OP_MTLO: lo_nxt = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (kill) begin
          count_nxt = 5'd0;
          state_nxt = IDLE;
        end else if (count == 5'd1) begin
          hi_nxt    = res_hi;
          lo_nxt    = res_lo;
          count_nxt = 5'd0;
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 5'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 5'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      op_q  <= op_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign busy  = (state == RUN);
  assign stall = md_use_d & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
`ifdef MDU_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .md_use_d (md_use_d),
`ifdef MDU_CANCEL_EN
    .cancel   (cancel),
`endif
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one op, count busy cycles (bounded), then compare HI/LO.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cyc,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; md_use_d = 1'b0;
`ifdef MDU_CANCEL_EN
    cancel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    // Arithmetic vectors
    run_md("mult",     3'd0, 32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu",    3'd1, 32'hFFFF_FFFE, 32'd3,         5,  32'h0000_0002, 32'hFFFF_FFFA);
    run_md("mult_max", 3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001);
    run_md("div",      3'd2, 32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu_z",   3'd3, 32'd7,         32'd0,         10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_md("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_md("div_z",    3'd2, 32'hFFFF_FFFB, 32'd0,         10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_md("divu",     3'd3, 32'hFFFF_FFF9, 32'd2,         10, 32'h0000_0001, 32'h7FFF_FFFC);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_hold", lo, 32'h7FFF_FFFC);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_hold", hi, 32'h1234_5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // Reserved op has no effect
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd1;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    chk("rsv_busy", {31'd0, busy}, 32'd0);
    chk("rsv_hi", hi, 32'h1234_5678);
    chk("rsv_lo", lo, 32'h9ABC_DEF0);

    // Stall window around a MULT with md_use_d held high
    md_use_d = 1'b1;
    #1 chk("stall_idle", {31'd0, stall}, 32'd0);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    #1 chk("stall_start", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_busy", {31'd0, stall}, 32'd1);
      chk("busy_win", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    #1;
    chk("stall_end", {31'd0, stall}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("stall_mult_hi", hi, 32'd0);
    chk("stall_mult_lo", lo, 32'd30);
    md_use_d = 1'b0;

    // Start while busy is dropped
    @(negedge clk);
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 2;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("ovl_cycles", 32'(n), 32'd10);
    chk("ovl_hi", hi, 32'd2);
    chk("ovl_lo", lo, 32'd14);

    // Reset in the middle of a DIV
    start = 1'b1; op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_md("post_rst", 3'd1, 32'd2, 32'd3, 5, 32'd0, 32'd6);

`ifdef MDU_CANCEL_EN
    // Cancel at busy cycle 3
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_busy", {31'd0, busy}, 32'd0);
    chk("cxl_hi", hi, 32'd0);
    chk("cxl_lo", lo, 32'd6);
    // Cancel coincident with MTHI
    start = 1'b1; op = 3'd4; a = 32'hDEAD_0001; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cxl_mthi_hi", hi, 32'd0);
    chk("cxl_mthi_busy", {31'd0, busy}, 32'd0);
    // Cancel in the final RUN cycle beats the write
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("cxl_last_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cxl_last_busy_after", {31'd0, busy}, 32'd0);
    chk("cxl_last_lo", lo, 32'd6);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
